draw_scoreboard: RTL and testbench



---
 rtl/draw_scoreboard.sv | 222 ++++++++++++++++++++++
 tb/tb_draw_scoreboard.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scoreboard.sv
// Score overlay stage: two seven-segment digits with goal flash and win blink.
// Optional SCOREBOARD_BACKDROP_EN blacks out unlit pixels inside the digit boxes.
module draw_scoreboard #(
  parameter int          WIN_SCORE    = 7,
  parameter int          FLASH_FRAMES = 60,
  parameter int          X_P1         = 464,
  parameter int          X_P2         = 528,
  parameter int          Y_TOP        = 8,
  parameter logic [11:0] P1_COLOR     = 12'hf_0_0,
  parameter logic [11:0] P2_COLOR     = 12'h0_0_b
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [3:0]  player_1_score,
  input  logic [3:0]  player_2_score,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        game_over
);

  typedef enum logic [1:0] {PLAY, FLASH, WIN} state_t;

  localparam logic [3:0]  WIN_S = 4'(WIN_SCORE);
  localparam logic [7:0]  FL_N  = 8'(FLASH_FRAMES);
  localparam logic [11:0] X1    = 12'(X_P1);
  localparam logic [11:0] X1E   = 12'(X_P1 + 32);
  localparam logic [11:0] X2    = 12'(X_P2);
  localparam logic [11:0] X2E   = 12'(X_P2 + 32);
  localparam logic [11:0] Y0    = 12'(Y_TOP);
  localparam logic [11:0] Y0E   = 12'(Y_TOP + 56);

  state_t      state, state_n;
  logic [3:0]  s1, s2;
  logic [7:0]  fcnt, fl_cnt, fl_cnt_n;
  logic [1:0]  mask, mask_n, winner, winner_n, inc;
  logic        vblnk_q, tick, win;

  // bit order {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_map(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic seg_on(input logic [11:0] dx,
                                  input logic [11:0] dy,
                                  input logic [6:0]  p);
    return (p[6] && dy < 12'd6)
        || (p[0] && dy >= 12'd25 && dy < 12'd31)
        || (p[3] && dy >= 12'd50)
        || (p[1] && dx < 12'd6  && dy < 12'd28)
        || (p[5] && dx >= 12'd26 && dy < 12'd28)
        || (p[2] && dx < 12'd6  && dy >= 12'd28)
        || (p[4] && dx >= 12'd26 && dy >= 12'd28);
  endfunction

  assign tick = vblnk_in & ~vblnk_q;
  assign inc  = {player_2_score > s2, player_1_score > s1};
  assign win  = (player_1_score >= WIN_S) | (player_2_score >= WIN_S);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      s1      <= '0;
      s2      <= '0;
      fcnt    <= '0;
    end else begin
      vblnk_q <= vblnk_in;
      if (tick) begin
        s1   <= player_1_score;
        s2   <= player_2_score;
        fcnt <= fcnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    mask_n   = mask;
    winner_n = winner;
    fl_cnt_n = fl_cnt;
    if (tick) begin
      if (win) begin
        state_n  = WIN;
        winner_n = {player_2_score >= player_1_score,
                    player_1_score >= player_2_score};
        mask_n   = '0;
      end else if (state == WIN) begin
        state_n  = PLAY;
        winner_n = '0;
      end else if (|inc) begin
        state_n  = FLASH;
        mask_n   = mask | inc;
        fl_cnt_n = FL_N;
      end else if (state == FLASH) begin
        fl_cnt_n = fl_cnt - 8'd1;
        if (fl_cnt == 8'd1) begin
          state_n = PLAY;
          mask_n  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= PLAY;
      mask      <= '0;
      winner    <= '0;
      fl_cnt    <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      mask      <= mask_n;
      winner    <= winner_n;
      fl_cnt    <= fl_cnt_n;
      game_over <= (state_n == WIN);
    end
  end

  logic        in1, in2, hide1, hide2, on1, on2, bd;
  logic [11:0] dx1, dx2, dy;

  assign in1 = hcount_in >= X1 && hcount_in < X1E
            && vcount_in >= Y0 && vcount_in < Y0E;
  assign in2 = hcount_in >= X2 && hcount_in < X2E
            && vcount_in >= Y0 && vcount_in < Y0E;
  assign dx1 = hcount_in - X1;
  assign dx2 = hcount_in - X2;
  assign dy  = vcount_in - Y0;

  assign hide1 = fcnt[3] & ((state == FLASH & mask[0])
                          | (state == WIN & winner[0]));
  assign hide2 = fcnt[3] & ((state == FLASH & mask[1])
                          | (state == WIN & winner[1]));
  assign on1 = in1 & ~hide1 & seg_on(dx1, dy, seg_map(s1));
  assign on2 = in2 & ~hide2 & seg_on(dx2, dy, seg_map(s2));

`ifdef SCOREBOARD_BACKDROP_EN
  assign bd = in1 | in2;
`else
  assign bd = 1'b0;
`endif

  logic [11:0] hc1, vc1, rgb1;
  logic        hs1, vs1, hb1, vb1, on1_q, on2_q, bd_q, blank_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hc1     <= '0;
      vc1     <= '0;
      rgb1    <= '0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      hb1     <= 1'b0;
      vb1     <= 1'b0;
      on1_q   <= 1'b0;
      on2_q   <= 1'b0;
      bd_q    <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      hc1     <= hcount_in;
      vc1     <= vcount_in;
      rgb1    <= rgb_in;
      hs1     <= hsync_in;
      vs1     <= vsync_in;
      hb1     <= hblnk_in;
      vb1     <= vblnk_in;
      on1_q   <= on1;
      on2_q   <= on2;
      bd_q    <= bd;
      blank_q <= hblnk_in | vblnk_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hc1;
      vcount_out <= vc1;
      hsync_out  <= hs1;
      vsync_out  <= vs1;
      hblnk_out  <= hb1;
      vblnk_out  <= vb1;
      if (blank_q)    rgb_out <= rgb1;
      else if (on1_q) rgb_out <= P1_COLOR;
      else if (on2_q) rgb_out <= P2_COLOR;
      else if (bd_q)  rgb_out <= 12'h0_0_0;
      else            rgb_out <= rgb1;
    end
  end

endmodule

// File: tb/tb_draw_scoreboard.sv
// Directed bench for draw_scoreboard: glyph table, reset, flash, restart, win.
// Frames are synthesised as short vblnk pulses between probe pixels.
module tb_draw_scoreboard;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0;
  logic        hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [3:0]  player_1_score = '0, player_2_score = '0;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, game_over;

  draw_scoreboard dut (
    .clk_in(clk_in), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .player_1_score(player_1_score), .player_2_score(player_2_score),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .game_over(game_over)
  );

  always #5 clk_in = ~clk_in;

`ifdef SCOREBOARD_BACKDROP_EN
  localparam bit BD = 1'b1;
`else
  localparam bit BD = 1'b0;
`endif
  localparam logic [11:0] RGB = 12'h5a5;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] fc;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  lit;
    logic        inbox;
    logic        blank;
    string       nm;
  } vec_t;

  vec_t vt[20];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pix(input logic [1:0] lit,
                                      input logic hid,
                                      input logic inbox,
                                      input logic blank);
    if (blank) return RGB;
    if (lit == 2'd1 && !hid) return 12'hf00;
    if (lit == 2'd2 && !hid) return 12'h00b;
    if (BD && inbox) return 12'h000;
    return RGB;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    vblnk_in = 1'b0;
    hblnk_in = 1'b0;
    rgb_in = RGB;
    player_1_score = '0;
    player_2_score = '0;
    step();
    step();
    rst = 1'b0;
    step();
    fc = '0;
  endtask

  task automatic frame();
    vblnk_in = 1'b1;
    step();
    vblnk_in = 1'b0;
    step();
    fc = fc + 8'd1;
  endtask

  task automatic probe(input logic [11:0] x, input logic [11:0] y,
                       input logic blank, output logic [11:0] res);
    hcount_in = x;
    vcount_in = y;
    hblnk_in = blank;
    step();
    step();
    res = rgb_out;
    hblnk_in = 1'b0;
  endtask

  logic [11:0] r;

  initial begin
    vt[0]  = '{4'd3,  4'd0, 12'd470, 12'd10, 2'd1, 1'b1, 1'b0, "seg_a_3"};
    vt[1]  = '{4'd3,  4'd0, 12'd470, 12'd40, 2'd0, 1'b1, 1'b0, "seg_e_off_3"};
    vt[2]  = '{4'd3,  4'd0, 12'd530, 12'd30, 2'd2, 1'b1, 1'b0, "seg_f_0"};
    vt[3]  = '{4'd12, 4'd0, 12'd470, 12'd35, 2'd1, 1'b1, 1'b0, "dash_g"};
    vt[4]  = '{4'd12, 4'd0, 12'd470, 12'd10, 2'd0, 1'b1, 1'b0, "dash_a_off"};
    vt[5]  = '{4'd12, 4'd0, 12'd466, 12'd20, 2'd0, 1'b1, 1'b0, "dash_f_off"};
    vt[6]  = '{4'd1,  4'd5, 12'd464, 12'd10, 2'd0, 1'b1, 1'b0, "one_a_off"};
    vt[7]  = '{4'd1,  4'd5, 12'd490, 12'd10, 2'd1, 1'b1, 1'b0, "one_b"};
    vt[8]  = '{4'd1,  4'd5, 12'd554, 12'd40, 2'd2, 1'b1, 1'b0, "five_c"};
    vt[9]  = '{4'd1,  4'd5, 12'd554, 12'd20, 2'd0, 1'b1, 1'b0, "five_b_off"};
    vt[10] = '{4'd0,  4'd0, 12'd495, 12'd8,  2'd1, 1'b1, 1'b0, "edge_right"};
    vt[11] = '{4'd0,  4'd0, 12'd496, 12'd8,  2'd0, 1'b0, 1'b0, "out_right"};
    vt[12] = '{4'd0,  4'd0, 12'd464, 12'd63, 2'd1, 1'b1, 1'b0, "edge_bottom"};
    vt[13] = '{4'd0,  4'd0, 12'd464, 12'd64, 2'd0, 1'b0, 1'b0, "out_bottom"};
    vt[14] = '{4'd0,  4'd0, 12'd463, 12'd10, 2'd0, 1'b0, 1'b0, "out_left"};
    vt[15] = '{4'd4,  4'd0, 12'd466, 12'd30, 2'd1, 1'b1, 1'b0, "four_f"};
    vt[16] = '{4'd4,  4'd0, 12'd470, 12'd60, 2'd0, 1'b1, 1'b0, "four_d_off"};
    vt[17] = '{4'd0,  4'd0, 12'd480, 12'd36, 2'd0, 1'b1, 1'b0, "zero_g_off"};
    vt[18] = '{4'd3,  4'd0, 12'd470, 12'd10, 2'd0, 1'b1, 1'b1, "blank_pass"};
    vt[19] = '{4'd9,  4'd0, 12'd490, 12'd40, 2'd1, 1'b1, 1'b0, "nine_c"};

    fc = '0;
    // reset behaviour, asynchronous assertion mid-cycle
    do_reset();
    chk("go_reset", 12'(game_over), 12'h0);
    hcount_in = 12'd100;
    vcount_in = 12'd200;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rgb_in = 12'hfff;
    step();
    step();
    chk("pre_rst_rgb", rgb_out, 12'hfff);
    #2 rst = 1'b1;
    #1;
    chk("rst_rgb", rgb_out, 12'h0);
    chk("rst_hcount", hcount_out, 12'h0);
    chk("rst_vcount", vcount_out, 12'h0);
    chk("rst_hsync", 12'(hsync_out), 12'h0);
    chk("rst_vsync", 12'(vsync_out), 12'h0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("rel_rgb", rgb_out, 12'hfff);
    chk("rel_hcount", hcount_out, 12'd100);
    chk("rel_vcount", vcount_out, 12'd200);
    chk("rel_hsync", 12'(hsync_out), 12'h1);
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // glyph table
    for (int i = 0; i < 20; i++) begin
      do_reset();
      player_1_score = vt[i].a;
      player_2_score = vt[i].b;
      frame();
      probe(vt[i].x, vt[i].y, vt[i].blank, r);
      chk(vt[i].nm, r, pix(vt[i].lit, 1'b0, vt[i].inbox, vt[i].blank));
    end

    // shadow registers hold until the next frame tick
    do_reset();
    player_1_score = 4'd3;
    frame();
    player_1_score = 4'd4;
    probe(12'd470, 12'd10, 1'b0, r);
    chk("no_tear", r, pix(2'd1, 1'b0, 1'b1, 1'b0));

    // goal flash for player 2
    do_reset();
    frame();
    player_2_score = 4'd1;
    frame();
    for (int k = 0; k < 70; k++) begin
      probe(12'd554, 12'd20, 1'b0, r);
      chk("flash_d2", r, pix(2'd2, fc[3] && k < 60, 1'b1, 1'b0));
      probe(12'd470, 12'd10, 1'b0, r);
      chk("flash_d1", r, pix(2'd1, 1'b0, 1'b1, 1'b0));
      frame();
    end

    // simultaneous goal, then restart by a player 1 goal
    do_reset();
    frame();
    player_1_score = 4'd1;
    player_2_score = 4'd1;
    frame();
    while (fc < 8'd8) frame();
    probe(12'd490, 12'd10, 1'b0, r);
    chk("both_d1_hid", r, pix(2'd1, 1'b1, 1'b1, 1'b0));
    probe(12'd554, 12'd20, 1'b0, r);
    chk("both_d2_hid", r, pix(2'd2, 1'b1, 1'b1, 1'b0));
    while (fc < 8'd9) frame();
    player_1_score = 4'd2;
    frame();
    while (fc < 8'd62) frame();
    probe(12'd470, 12'd10, 1'b0, r);
    chk("restart_hid", r, pix(2'd1, 1'b1, 1'b1, 1'b0));
    while (fc < 8'd72) frame();
    probe(12'd470, 12'd10, 1'b0, r);
    chk("restart_end", r, pix(2'd1, 1'b0, 1'b1, 1'b0));

    // win by player 1, then back to play
    do_reset();
    player_1_score = 4'd6;
    frame();
    player_1_score = 4'd7;
    vblnk_in = 1'b1;
    chk("go_tick_cyc", 12'(game_over), 12'h0);
    step();
    chk("go_after", 12'(game_over), 12'h1);
    vblnk_in = 1'b0;
    step();
    fc = fc + 8'd1;
    while (fc < 8'd30) begin
      probe(12'd470, 12'd10, 1'b0, r);
      chk("win_d1", r, pix(2'd1, fc[3], 1'b1, 1'b0));
      probe(12'd530, 12'd30, 1'b0, r);
      chk("win_d2", r, pix(2'd2, 1'b0, 1'b1, 1'b0));
      frame();
    end
    chk("go_hold", 12'(game_over), 12'h1);
    player_1_score = 4'd0;
    player_2_score = 4'd0;
    frame();
    chk("go_clear", 12'(game_over), 12'h0);
    probe(12'd470, 12'd10, 1'b0, r);
    chk("play_visible", r, pix(2'd1, 1'b0, 1'b1, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
